// File: rtl/adc_spi_master.sv
`timescale 1ns/1ps
// adc_spi_master: runs one MCP3008-style single-ended conversion on one of two SPI ADCs per go pulse.
// Latency: adc_valid rises 35*SCLK_HALF clocks after the go-accept edge; next go is accepted CS_HIGH_MIN clocks later.
// Backpressure: none; adc_go is ignored (not queued) while adc_busy=1. Optional macro ADC_NULL_BIT_CHECK_EN.
module adc_spi_master #(
    parameter int SCLK_HALF   = 1,
    parameter int CS_HIGH_MIN = 2
) (
    input  logic       clk3p2M,
    input  logic       rst_n,
    input  logic       adc_go,
    input  logic [3:0] adc_chan,
    output logic [9:0] adc_in,
    output logic       adc_valid,
    output logic       adc_busy,
    output logic       adc_err,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [1:0] adc_cs_n
);

    localparam int DIV_W  = $clog2(SCLK_HALF + 1);
    localparam int HOLD_W = $clog2(CS_HIGH_MIN + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_HALF - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HIGH_MIN - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t              r_state, w_state;
    logic [DIV_W-1:0]    r_div, w_div;
    logic [4:0]          r_bit, w_bit;
    logic [HOLD_W-1:0]   r_hold, w_hold;
    logic [2:0]          r_chan, w_chan;
    logic [9:0]          r_shift, w_shift;
    logic [9:0]          r_in, w_in;
    logic                r_sclk, w_sclk;
    logic                r_mosi, w_mosi;
    logic [1:0]          r_cs_n, w_cs_n;
    logic                r_valid, w_valid;
    logic                r_busy, w_busy;
    logic                w_accept;
    logic                w_mosi_next;
`ifdef ADC_NULL_BIT_CHECK_EN
    logic                r_null, w_null;
    logic                r_err, w_err;
`endif

    assign adc_in    = r_in;
    assign adc_valid = r_valid;
    assign adc_busy  = r_busy;
    assign spi_sclk  = r_sclk;
    assign spi_mosi  = r_mosi;
    assign adc_cs_n  = r_cs_n;
`ifdef ADC_NULL_BIT_CHECK_EN
    assign adc_err   = r_err;
`else
    assign adc_err   = 1'b0;
`endif

    // State and datapath registers; reset aborts any frame in flight by releasing both chip selects.
    always_ff @(posedge clk3p2M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_hold  <= '0;
            r_chan  <= '0;
            r_shift <= '0;
            r_in    <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= 2'b11;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
`ifdef ADC_NULL_BIT_CHECK_EN
            r_null  <= 1'b0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_hold  <= w_hold;
            r_chan  <= w_chan;
            r_shift <= w_shift;
            r_in    <= w_in;
            r_sclk  <= w_sclk;
            r_mosi  <= w_mosi;
            r_cs_n  <= w_cs_n;
            r_valid <= w_valid;
            r_busy  <= w_busy;
`ifdef ADC_NULL_BIT_CHECK_EN
            r_null  <= w_null;
            r_err   <= w_err;
`endif
        end
    end

    // Next-state and SPI sequencing. A go is also taken in the last HOLD cycle so the CS-high gap is exactly CS_HIGH_MIN.
    always_comb begin
        w_state     = r_state;
        w_div       = r_div;
        w_bit       = r_bit;
        w_hold      = r_hold;
        w_chan      = r_chan;
        w_shift     = r_shift;
        w_in        = r_in;
        w_sclk      = r_sclk;
        w_mosi      = r_mosi;
        w_cs_n      = r_cs_n;
        w_valid     = 1'b0;
        w_busy      = r_busy;
`ifdef ADC_NULL_BIT_CHECK_EN
        w_null      = r_null;
        w_err       = r_err;
`endif
        w_accept    = adc_go && ((r_state == IDLE) ||
                                 ((r_state == HOLD) && (r_hold == HOLD_LAST)));

        // Command bit for the period following r_bit: start, single-ended, D2, D1, D0, then zeros.
        case (r_bit)
            5'd0:    w_mosi_next = 1'b1;
            5'd1:    w_mosi_next = r_chan[2];
            5'd2:    w_mosi_next = r_chan[1];
            5'd3:    w_mosi_next = r_chan[0];
            default: w_mosi_next = 1'b0;
        endcase

        case (r_state)
            IDLE: begin
            end
            SETUP: begin
                if (r_div == DIV_LAST) begin
                    w_div   = '0;
                    w_sclk  = 1'b1;
                    w_bit   = '0;
                    w_state = SHIFT;
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            SHIFT: begin
                if (r_div != DIV_LAST) begin
                    w_div = r_div + 1'b1;
                end else begin
                    w_div = '0;
                    if (r_sclk) begin
                        // Falling SCLK: sample MISO and present the next command bit.
                        w_sclk = 1'b0;
                        w_mosi = w_mosi_next;
                        if (r_bit >= 5'd7) begin
                            w_shift = {r_shift[8:0], spi_miso};
                        end
`ifdef ADC_NULL_BIT_CHECK_EN
                        if (r_bit == 5'd6) begin
                            w_null = spi_miso;
                        end
`endif
                    end else if (r_bit == 5'd16) begin
                        // End of the last low half: release CS and publish the result.
                        w_cs_n  = 2'b11;
                        w_state = HOLD;
                        w_hold  = '0;
                        w_busy  = (HOLD_LAST != '0);
`ifdef ADC_NULL_BIT_CHECK_EN
                        if (r_null) begin
                            w_err = 1'b1;
                        end else begin
                            w_in    = r_shift;
                            w_valid = 1'b1;
                        end
`else
                        w_in    = r_shift;
                        w_valid = 1'b1;
`endif
                    end else begin
                        w_sclk = 1'b1;
                        w_bit  = (r_bit == 5'd16) ? r_bit : r_bit + 5'd1;
                    end
                end
            end
            HOLD: begin
                if (r_hold != HOLD_LAST) begin
                    w_hold = r_hold + 1'b1;
                    if (w_hold == HOLD_LAST) begin
                        w_busy = 1'b0;
                    end
                end else begin
                    w_state = IDLE;
                    w_busy  = 1'b0;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        if (w_accept) begin
            w_state = SETUP;
            w_div   = '0;
            w_bit   = '0;
            w_chan  = adc_chan[2:0];
            w_cs_n  = adc_chan[3] ? 2'b01 : 2'b10;
            w_mosi  = 1'b1;
            w_busy  = 1'b1;
`ifdef ADC_NULL_BIT_CHECK_EN
            w_err   = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_adc_spi_master.sv
`timescale 1ns/1ps
// tb_adc_spi_master: directed frames against two instances (SCLK_HALF=1 and SCLK_HALF=3) with an MCP3008-style model.
// Latency: expected results are queued at go time and compared when adc_valid is seen.
// Backpressure: none; all waits are bounded by cycle budgets.
module tb_adc_spi_master;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      go;
    logic [1:0][3:0] chan;
    logic [1:0][9:0] ain;
    logic [1:0]      vld, busy, err, sclk, mosi;
    logic [1:0]      miso = 2'b00;
    logic [1:0][1:0] cs;

    logic [1:0][9:0] md;
    logic [1:0]      mnull;
    int              mcnt [2];
    logic [1:0]      psclk = 2'b00;
    logic [1:0][4:0] mmosi;

    logic [9:0]      sbq [$];
    int              n_vec = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    adc_spi_master #(.SCLK_HALF(1), .CS_HIGH_MIN(2)) u_dut0 (
        .clk3p2M(clk), .rst_n(rst_n), .adc_go(go[0]), .adc_chan(chan[0]),
        .adc_in(ain[0]), .adc_valid(vld[0]), .adc_busy(busy[0]), .adc_err(err[0]),
        .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]), .adc_cs_n(cs[0])
    );

    adc_spi_master #(.SCLK_HALF(3), .CS_HIGH_MIN(2)) u_dut3 (
        .clk3p2M(clk), .rst_n(rst_n), .adc_go(go[1]), .adc_chan(chan[1]),
        .adc_in(ain[1]), .adc_valid(vld[1]), .adc_busy(busy[1]), .adc_err(err[1]),
        .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]), .adc_cs_n(cs[1])
    );

    // ADC model: on each SCLK rise inside a frame, capture MOSI for bits 0-4 and drive MISO for that bit.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs[i] === 2'b11) begin
                mcnt[i] = 0;
                miso[i] = 1'b0;
            end else if (sclk[i] === 1'b1 && psclk[i] !== 1'b1) begin
                if (mcnt[i] == 0) mmosi[i] = 5'd0;
                if (mcnt[i] < 5) mmosi[i][mcnt[i]] = mosi[i];
                if (mcnt[i] == 6) miso[i] = mnull[i];
                else if (mcnt[i] >= 7 && mcnt[i] <= 16) miso[i] = md[i][16 - mcnt[i]];
                else miso[i] = 1'b0;
                mcnt[i]++;
            end
            psclk[i] = sclk[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int i, input logic [3:0] ch, input logic [9:0] d,
                             input logic nb, input int h, input bit expv);
        logic [9:0] prev;
        int         got;
        int         run;
        int         rbad;
        logic       ps;
        md[i]    = d;
        mnull[i] = nb;
        chan[i]  = ch;
        prev     = ain[i];
        if (expv) sbq.push_back(d);
        go[i] = 1'b1;
        tick();
        go[i]   = 1'b0;
        chan[i] = ~ch;
        chk("cs_low", cs[i], ch[3] ? 2'b01 : 2'b10);
        chk("busy_set", busy[i], 1);
        chk("err_clr_on_go", err[i], 0);
        got = 0; run = 1; rbad = 0; ps = sclk[i];
        for (int c = 1; c <= 40 * h; c++) begin
            tick();
            if (sclk[i] === ps) run++;
            else begin
                if (run != h) rbad++;
                run = 1;
                ps  = sclk[i];
            end
            if (vld[i] === 1'b1) begin
                got = c;
                break;
            end
        end
        chk("sclk_half_len", rbad, 0);
        chk("mosi_cmd", mmosi[i], {ch[0], ch[1], ch[2], 2'b11});
        if (expv) begin
            chk("valid_latency", got, 35 * h);
            if (got != 0) begin
                chk("adc_in", ain[i], sbq.pop_front());
                chk("cs_release", cs[i], 2'b11);
            end
            tick();
            chk("valid_one_cycle", vld[i], 0);
            chk("busy_drop", busy[i], 0);
            chk("err_low", err[i], 0);
        end else begin
            chk("no_valid", got, 0);
            chk("adc_in_kept", ain[i], prev);
`ifdef ADC_NULL_BIT_CHECK_EN
            chk("err_set", err[i], 1);
`endif
        end
    endtask

    initial begin
        int nv;
        int got;
        rst_n = 1'b0;
        go    = '0;
        chan  = '0;
        md    = '0;
        mnull = '0;
        repeat (3) tick();
        chk("rst_cs", cs[0], 2'b11);
        chk("rst_sclk", sclk[0], 0);
        chk("rst_mosi", mosi[0], 0);
        chk("rst_in", ain[0], 0);
        chk("rst_valid", vld[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_err", err[0], 0);
        rst_n = 1'b1;
        tick();

        run_frame(0, 4'd5, 10'h2A5, 1'b0, 1, 1'b1);
        run_frame(0, 4'd12, 10'h3FF, 1'b0, 1, 1'b1);

        // go held high across a whole frame: one frame, then restart exactly CS_HIGH_MIN after valid
        md[0] = 10'h0C3; mnull[0] = 1'b0; chan[0] = 4'd3;
        sbq.push_back(10'h0C3);
        sbq.push_back(10'h0C3);
        go[0] = 1'b1;
        tick();
        nv = 0;
        for (int c = 1; c <= 37; c++) begin
            tick();
            if (vld[0] === 1'b1) nv++;
            if (c == 35) begin
                chk("held_valid_35", vld[0], 1);
                chk("held_adc_in", ain[0], sbq.pop_front());
            end
            if (c == 35 || c == 36) chk("cs_gap_high", cs[0], 2'b11);
            if (c == 37) begin
                chk("restart_37", cs[0], 2'b10);
                chk("restart_busy", busy[0], 1);
            end
        end
        go[0] = 1'b0;
        chk("one_frame_only", nv, 1);
        got = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (vld[0] === 1'b1) begin
                got = c;
                break;
            end
        end
        chk("second_latency", got, 35);
        if (got != 0) chk("second_adc_in", ain[0], sbq.pop_front());
        tick();

        // null bit driven high
`ifdef ADC_NULL_BIT_CHECK_EN
        run_frame(0, 4'd9, 10'h155, 1'b1, 1, 1'b0);
        run_frame(0, 4'd2, 10'h0F0, 1'b0, 1, 1'b1);
`else
        run_frame(0, 4'd9, 10'h155, 1'b1, 1, 1'b1);
`endif

        // reset in the middle of a frame
        md[0] = 10'h2AA; mnull[0] = 1'b0; chan[0] = 4'd7;
        go[0] = 1'b1;
        tick();
        go[0] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mcnt[0] >= 10) break;
            tick();
        end
        chk("reached_bit9", cs[0], 2'b10);
        rst_n = 1'b0;
        #1;
        chk("abort_cs", cs[0], 2'b11);
        chk("abort_sclk", sclk[0], 0);
        chk("abort_mosi", mosi[0], 0);
        chk("abort_in", ain[0], 0);
        chk("abort_valid", vld[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_err", err[0], 0);
        tick();
        tick();
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (vld[0] === 1'b1) nv++;
        end
        chk("abort_no_valid", nv, 0);
        run_frame(0, 4'd0, 10'h1E7, 1'b0, 1, 1'b1);

        // slow SCLK instance
        run_frame(1, 4'd1, 10'h001, 1'b0, 3, 1'b1);
        run_frame(1, 4'd14, 10'h2F0, 1'b0, 3, 1'b1);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
